register_scoreboard: RTL

//  Integer register file plus long-latency write scoreboard. Supplies the rdata1/rdata2 operands consumed by forwarding.

---
 rtl/register_scoreboard_pkg.sv | 39 +++
 rtl/register_scoreboard_if.sv | 36 +++
 rtl/register_scoreboard_register_array.sv | 32 +++
 rtl/register_scoreboard.sv | 86 ++++++++
 4 files changed

// File: rtl/register_scoreboard_pkg.sv
// Shared types and constants for the integer register file and long-op scoreboard.
package register_scoreboard_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       en;
    logic [4:0] addr;
  } register_read_in_type;

  typedef struct packed {
    logic zero;
    logic bypass;
    logic retiring;
  } register_read_out_type;

  typedef struct packed {
    logic       valid;
    logic       long_op;
    logic [4:0] waddr;
  } scoreboard_issue_type;

  typedef struct packed {
    logic       wren;
    logic       long_done;
    logic [4:0] waddr;
  } writeback_type;

  // Decodes how a read port is served this cycle relative to the writeback port.
  function automatic register_read_out_type classify_read(input register_read_in_type rd,
                                                          input writeback_type wb);
    register_read_out_type r;
    r.zero     = !rd.en || (rd.addr == REG_ZERO);
    r.bypass   = !r.zero && wb.wren && (wb.waddr == rd.addr);
    r.retiring = !r.zero && wb.long_done && (wb.waddr == rd.addr);
    return r;
  endfunction

endpackage

// File: rtl/register_scoreboard_if.sv
// Decode/writeback-facing signal bundle of the register scoreboard.
interface register_scoreboard_if #(
  parameter int XLEN = 32
);
  logic            rden1;
  logic            rden2;
  logic [4:0]      raddr1;
  logic [4:0]      raddr2;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic            stall;
  logic            issue_valid;
  logic            issue_long;
  logic [4:0]      issue_waddr;
  logic            issue_ready;
  logic            wb_wren;
  logic [4:0]      wb_waddr;
  logic [XLEN-1:0] wb_wdata;
  logic            wb_long_done;
  logic            flush;
  logic            busy;

  modport master (
    output rden1, rden2, raddr1, raddr2,
    output issue_valid, issue_long, issue_waddr,
    output wb_wren, wb_waddr, wb_wdata, wb_long_done, flush,
    input  rdata1, rdata2, stall, issue_ready, busy
  );

  modport slave (
    input  rden1, rden2, raddr1, raddr2,
    input  issue_valid, issue_long, issue_waddr,
    input  wb_wren, wb_waddr, wb_wdata, wb_long_done, flush,
    output rdata1, rdata2, stall, issue_ready, busy
  );
endinterface

// File: rtl/register_scoreboard_register_array.sv
// 31 x XLEN register storage, two async read ports, one write port; x0 hardwired to zero.
module register_array #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            wren,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);
  import register_scoreboard_pkg::*;

  logic [XLEN-1:0] mem [1:31];

  // Storage is intentionally not reset; contents survive a pipeline reset.
  always_ff @(posedge clock) begin
    if (wren && (waddr != REG_ZERO)) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != REG_ZERO) rdata1 = mem[raddr1];
    if (raddr2 != REG_ZERO) rdata2 = mem[raddr2];
  end

endmodule

// File: rtl/register_scoreboard.sv
// Register file plus pending-destination scoreboard for long-latency ops (load, div).
module register_scoreboard #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int XLEN            = 32
) (
  input logic                  clock,
  input logic                  reset,
  register_scoreboard_if.slave bus
);
  import register_scoreboard_pkg::*;

  localparam int                CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  register_read_in_type  rd1, rd2;
  register_read_out_type rc1, rc2;
  scoreboard_issue_type  iss;
  writeback_type         wb;

  logic [XLEN-1:0]  arr_rdata1, arr_rdata2;
  logic [31:0]      pending;
  logic [CNT_W-1:0] outstanding;
  logic             accept, set_en, clr_en, stall1, stall2;

  assign rd1 = '{en: bus.rden1, addr: bus.raddr1};
  assign rd2 = '{en: bus.rden2, addr: bus.raddr2};
  assign iss = '{valid: bus.issue_valid, long_op: bus.issue_long, waddr: bus.issue_waddr};
  assign wb  = '{wren: bus.wb_wren, long_done: bus.wb_long_done, waddr: bus.wb_waddr};

  assign rc1 = classify_read(rd1, wb);
  assign rc2 = classify_read(rd2, wb);

  register_array #(.XLEN(XLEN)) u_array (
    .clock  (clock),
    .wren   (wb.wren),
    .waddr  (wb.waddr),
    .wdata  (bus.wb_wdata),
    .raddr1 (rd1.addr),
    .raddr2 (rd2.addr),
    .rdata1 (arr_rdata1),
    .rdata2 (arr_rdata2)
  );

  assign bus.rdata1 = rc1.zero ? '0 : (rc1.bypass ? bus.wb_wdata : arr_rdata1);
  assign bus.rdata2 = rc2.zero ? '0 : (rc2.bypass ? bus.wb_wdata : arr_rdata2);

  // A register retiring this cycle is served by the write-through bypass, so it does not stall.
  assign stall1    = !rc1.zero && pending[rd1.addr] && !rc1.retiring;
  assign stall2    = !rc2.zero && pending[rd2.addr] && !rc2.retiring;
  assign bus.stall = stall1 || stall2;

  assign bus.issue_ready = (outstanding != MAX_CNT);
  assign bus.busy        = (outstanding != '0);

  assign accept = iss.valid && bus.issue_ready && iss.long_op;
  assign set_en = accept && (iss.waddr != REG_ZERO);
  assign clr_en = wb.long_done && (wb.waddr != REG_ZERO);

  // Clear is applied before set so a new producer to the same register supersedes the old one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else if (bus.flush) begin
      pending <= '0;
    end else begin
      if (clr_en) pending[wb.waddr]  <= 1'b0;
      if (set_en) pending[iss.waddr] <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else if (bus.flush) begin
      outstanding <= '0;
    end else if (accept && !wb.long_done) begin
      outstanding <= outstanding + CNT_W'(1);
    end else if (!accept && wb.long_done && (outstanding != '0)) begin
      outstanding <= outstanding - CNT_W'(1);
    end
  end

  no_retire_underflow: assert property (@(posedge clock) disable iff (reset)
    !(wb.long_done && !accept && !bus.flush && (outstanding == '0)));

endmodule
